// File: rtl/pipelined_accumulate_machine.sv
// Streams `length` words from a combinational-read memory through a registered
// fetch stage into an add / subtract / saturating-add accumulator.
module pipelined_accumulate_machine #(
  parameter int WIDTH = 32,
  parameter int AW    = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    length,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0]    ONE  = AW'(1);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, nxt;
  logic [AW-1:0]    idx, rem;
  logic [WIDTH-1:0] dreg, acc, res, sum, diff;
  logic [1:0]       mode_q;
  logic             vld, ovf, ov, add_ovf, sub_ovf;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = (length != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (!hold && rem == ONE) nxt = S_DRAIN;
      S_DRAIN: if (!hold) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_FETCH) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Signed overflow: operands agree (add) or differ (sub) in sign and the
  // result's sign departs from the accumulator's.
  always_comb begin
    sum     = acc + dreg;
    diff    = acc - dreg;
    add_ovf = (acc[WIDTH-1] == dreg[WIDTH-1]) && (sum[WIDTH-1]  != acc[WIDTH-1]);
    sub_ovf = (acc[WIDTH-1] != dreg[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
    res     = sum;
    ov      = add_ovf;
    case (mode_q)
      2'b01: begin res = diff; ov = sub_ovf; end
      2'b10: if (add_ovf) res = acc[WIDTH-1] ? SMIN : SMAX;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx    <= '0;
      rem    <= '0;
      dreg   <= '0;
      acc    <= '0;
      mode_q <= '0;
      vld    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc <= '0;
          ovf <= 1'b0;
          vld <= 1'b0;
          if (length != '0) begin
            idx    <= base;
            rem    <= length;
            mode_q <= mode;
          end
        end
        S_FETCH, S_DRAIN: if (!hold) begin
          if (vld) begin
            acc <= res;
            ovf <= ovf | ov;
          end
          if (state == S_FETCH) begin
            dreg <= mem_data;
            vld  <= 1'b1;
            idx  <= idx + ONE;
            rem  <= rem - ONE;
          end else begin
            vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = idx;
  assign out      = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_pipelined_accumulate_machine.sv
// Directed bench: runs a handful of accumulate jobs against a small memory and
// checks addresses, done timing, result and overflow against hand-computed values.
module tb_pipelined_accumulate_machine;
  localparam int W = 32;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset, start, hold;
  logic [A-1:0] base, length, mem_addr;
  logic [1:0]   mode;
  logic [W-1:0] mem_data, out;
  logic         busy, done, overflow;
  logic [W-1:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  pipelined_accumulate_machine #(.WIDTH(W), .AW(A)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
    .mode(mode), .hold(hold), .mem_addr(mem_addr), .mem_data(mem_data),
    .out(out), .busy(busy), .done(done), .overflow(overflow)
  );

  assign mem_data = mem[mem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts in the current cycle; sp = cycle of a stray start pulse,
  // hold is high for cycles hf .. hf+hc-1. Returns at the idle cycle after done.
  task automatic run(input string tag, input logic [A-1:0] b, input logic [A-1:0] n,
                     input logic [1:0] m, input int sp, input int hf, input int hc,
                     input logic [W-1:0] eo, input logic eov, input int ec);
    int c, f;
    logic [A-1:0] a;
    logic hd;
    start = 1'b1; base = b; length = n; mode = m;
    @(negedge clk);
    start = 1'b0;
    c = 1; f = 0; a = b;
    chk({tag, " out@1"}, out, '0);
    chk({tag, " ovf@1"}, {31'b0, overflow}, 32'd0);
    while (!done && c < 64) begin
      hold  = (c >= hf) && (c < hf + hc);
      start = (c == sp);
      if (c == sp) begin base = 4'd9; length = 4'd7; mode = 2'b01; end
      if (f < int'(n)) chk({tag, " addr"}, {28'b0, mem_addr}, {28'b0, a});
      hd = hold;
      @(negedge clk);
      if (!hd && f < int'(n)) begin f++; a++; end
      c++;
    end
    hold = 1'b0; start = 1'b0;
    chk({tag, " done_cyc"}, c, ec);
    chk({tag, " out"}, out, eo);
    chk({tag, " ovf"}, {31'b0, overflow}, {31'b0, eov});
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    base = '0; length = '0; mode = '0;
    for (int i = 0; i < 16; i++) mem[i] = i + 1;
    repeat (2) @(negedge clk);
    chk("rst out",  out, '0);
    chk("rst addr", {28'b0, mem_addr}, 32'd0);
    chk("rst flags", {28'b0, busy, done, overflow, 1'b0}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run("add",   4'd0,  4'd4, 2'b00, 0, 0, 0, 32'd10, 1'b0, 6);
    run("stall", 4'd0,  4'd3, 2'b00, 0, 2, 2, 32'd6,  1'b0, 7);
    run("wrap",  4'd14, 4'd4, 2'b00, 0, 0, 0, 32'd34, 1'b0, 6);
    run("zero",  4'd3,  4'd0, 2'b00, 0, 0, 0, 32'd0,  1'b0, 1);
    run("ign",   4'd0,  4'd4, 2'b00, 2, 0, 0, 32'd10, 1'b0, 6);

    // Abandon a run with reset in cycle 3.
    start = 1'b1; base = 4'd0; length = 4'd4; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst out",  out, '0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | done;
      @(negedge clk);
    end
    chk("midrst no_done", {31'b0, seen}, 32'd0);
    run("fresh", 4'd0, 4'd4, 2'b00, 0, 0, 0, 32'd10, 1'b0, 6);

    mem[0] = 32'd5; mem[1] = 32'd3;
    @(negedge clk);
    run("sub",   4'd0, 4'd2, 2'b01, 0, 0, 0, 32'hFFFF_FFF8, 1'b0, 4);
    run("mode3", 4'd0, 4'd2, 2'b11, 0, 0, 0, 32'd8,         1'b0, 4);

    mem[0] = 32'h7FFF_FFF0; mem[1] = 32'h20;
    @(negedge clk);
    run("sat",   4'd0, 4'd2, 2'b10, 0, 0, 0, 32'h7FFF_FFFF, 1'b1, 4);
    run("wrapov",4'd0, 4'd2, 2'b00, 0, 0, 0, 32'h8000_0010, 1'b1, 4);
    run("b2b",   4'd0, 4'd1, 2'b00, 0, 0, 0, 32'h7FFF_FFF0, 1'b0, 3);

    mem[0] = 32'h8000_0010; mem[1] = 32'hFFFF_FF00;
    @(negedge clk);
    run("satneg",4'd0, 4'd2, 2'b10, 0, 0, 0, 32'h8000_0000, 1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
